// File: rtl/game_state_scanner.sv
// Snapshots a packed N-bit game-state word on start and streams it out as W-bit cells over a valid/ready handshake.
// Build option: define SCAN_CHECKSUM_EN to append one XOR-of-all-cells checksum cell after the data cells.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | presenting cell out_idx, advancing on each handshake
// DONE  | one-cycle done pulse, then back to IDLE
module game_state_scanner #(
  parameter int N     = 134,
  parameter int W     = 2,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic [N-1:0]     d,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done
);

  localparam int CHUNKS = (N + W - 1) / W;
`ifdef SCAN_CHECKSUM_EN
  localparam int LAST = CHUNKS;
`else
  localparam int LAST = CHUNKS - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                state_q;
  logic [CHUNKS*W-1:0]   snap_q;
  logic [CHUNKS*W-1:0]   snap_d;
  logic [W-1:0]          data_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  done_q;
  logic [IDX_W-1:0]      idx_d;
  logic [W-1:0]          cell_d;
`ifdef SCAN_CHECKSUM_EN
  logic [W-1:0]          csum_q;
`endif

  // Zero-pad the word up to a whole number of cells.
  always_comb begin
    snap_d        = '0;
    snap_d[N-1:0] = d;
  end

  assign idx_d = idx_q + IDX_W'(1);

  always_comb begin
    cell_d = snap_q[int'(idx_d)*W +: W];
`ifdef SCAN_CHECKSUM_EN
    // The checksum cell folds in the cell being accepted this cycle.
    if (idx_d == IDX_W'(CHUNKS)) cell_d = csum_q ^ data_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      snap_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q  <= snap_d;
            data_q  <= snap_d[W-1:0];
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= (LAST_IDX == '0);
`ifdef SCAN_CHECKSUM_EN
            csum_q  <= '0;
`endif
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              data_q  <= '0;
              idx_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_d;
              data_q  <= cell_d;
              last_q  <= (idx_d == LAST_IDX);
`ifdef SCAN_CHECKSUM_EN
              csum_q  <= csum_q ^ data_q;
`endif
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule
